// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Write side of the 32x32 register file. It merges ALU results and load
//   results onto the file's single write port. ALU results always win. Load
//   results that collide with an ALU write wait in a small FIFO. A pending-rd
//   scoreboard is exported so decode can stall on registers with queued loads.
//
// Parameters
//   DEPTH  load FIFO entries (power of 2, >= 2)
//   AW     register address width
//   DW     data width
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-low reset
//   alu_valid_i  ALU result valid; never back-pressured
//   alu_rd_i     ALU destination register
//   alu_data_i   ALU result
//   mem_valid_i  load result valid
//   mem_ready_o  load result accepted when mem_valid_i & mem_ready_o
//   mem_rd_i     load destination register
//   mem_data_i   load data
//   RegWrite_o   register-file write enable (registered)
//   RDaddr_o     register-file write address (registered)
//   RDdata_o     register-file write data (registered)
//   pending_o    bit r set = a live queued load targets register r
//   stall_cnt_o  cycles with mem_valid_i & !mem_ready_o (saturating)
//   kill_cnt_o   loads killed by WAW, queued or same-cycle (saturating)
//
// Build option
//   REGWB_STATS_EN  when defined, the two statistics counters are built.
//                   Otherwise both ports are tied to zero.
//
// Load handshake: a load transfers on any rising edge where mem_valid_i and
// mem_ready_o are both high. mem_ready_o depends only on FIFO state, never on
// mem_valid_i. The producer must hold rd/data stable while valid is high and
// ready is low. The ALU side has no ready signal and is always consumed.

module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  input  logic [AW-1:0]        alu_rd_i,
  input  logic [DW-1:0]        alu_data_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [AW-1:0]        mem_rd_i,
  input  logic [DW-1:0]        mem_data_i,
  output logic                 RegWrite_o,
  output logic [AW-1:0]        RDaddr_o,
  output logic [DW-1:0]        RDdata_o,
  output logic [(1<<AW)-1:0]   pending_o,
  output logic [15:0]          stall_cnt_o,
  output logic [15:0]          kill_cnt_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;  // extra bit separates full from empty

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;

  logic fifo_empty;
  logic fifo_full;
  logic alu_sel;
  logic mem_acc;
  logic mem_killed;
  logic mem_keep;
  logic pop;
  logic bypass;
  logic push;

  assign wr_idx     = wr_ptr[IW-1:0];
  assign rd_idx     = rd_ptr[IW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) &&
                      (wr_ptr[PW-1] != rd_ptr[PW-1]);

  assign mem_ready_o = !fifo_full;

  assign alu_sel    = alu_valid_i && (alu_rd_i != '0);
  assign mem_acc    = mem_valid_i && mem_ready_o;
  // A load accepted alongside an ALU write to the same rd counts as older, so it is dropped.
  assign mem_killed = alu_sel && mem_acc && (mem_rd_i == alu_rd_i);
  // Loads to x0 are accepted and discarded.
  assign mem_keep   = mem_acc && (mem_rd_i != '0) && !mem_killed;

  assign pop    = !alu_sel && !fifo_empty;
  assign bypass = !alu_sel && fifo_empty && mem_keep;
  assign push   = mem_keep && !bypass;

  // Scoreboard. Free slots are always dead because pop clears the live bit.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_o[rd_q[i]] = 1'b1;
    end
  end

  // Payload storage needs no reset; the live bits decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[wr_idx]   <= mem_rd_i;
      data_q[wr_idx] <= mem_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live_q <= '0;
    end else begin
      // WAW kill of queued loads. Dead entries keep their slot until popped.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_sel && (rd_q[i] == alu_rd_i)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_idx] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        live_q[wr_idx] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else if (alu_sel) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= alu_rd_i;
      RDdata_o   <= alu_data_i;
    end else if (pop) begin
      // A dead head still takes its slot in the write stream but writes nothing.
      RegWrite_o <= live_q[rd_idx];
      RDaddr_o   <= rd_q[rd_idx];
      RDdata_o   <= data_q[rd_idx];
    end else if (bypass) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= mem_rd_i;
      RDdata_o   <= mem_data_i;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

`ifdef REGWB_STATS_EN
  localparam int KW = $clog2(DEPTH + 2);
  localparam logic [KW-1:0] K_ONE = 1;

  logic [KW-1:0] kill_num;
  logic [16:0]   kill_sum;
  logic [15:0]   stall_cnt;
  logic [15:0]   kill_cnt;

  always_comb begin
    kill_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_sel && live_q[i] && (rd_q[i] == alu_rd_i)) kill_num = kill_num + K_ONE;
    end
    if (mem_killed) kill_num = kill_num + K_ONE;
  end

  assign kill_sum = {1'b0, kill_cnt} + {{(17-KW){1'b0}}, kill_num};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (mem_valid_i && !mem_ready_o && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign kill_cnt_o  = kill_cnt;
`else
  assign stall_cnt_o = '0;
  assign kill_cnt_o  = '0;
`endif

endmodule
